// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
// Request/result bundle between the EX-stage control and the HI/LO
// multiply/divide unit.
//
// Signals:
//   start  request strobe, sampled on the rising clock edge
//   op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//          11x no-op
//   a      rs operand (dividend / multiplicand / MTHI-MTLO source)
//   b      rt operand (divisor / multiplier)
//   hi     architectural HI register
//   lo     architectural LO register
//   busy   high while a multiply/divide is in progress
//   done   one-cycle pulse after HI/LO are committed by a mul/div
//
// Modports:
//   master  issues requests (pipeline side, testbench)
//   slave   the unit itself
// ---------------------------------------------------------------------------
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative multiply/divide unit holding the MIPS32 HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per
// clock for WIDTH clocks, followed by a single fix-up clock that applies the
// sign correction and commits HI/LO. MTHI/MTLO complete in one clock.
//
// Ports:
//   clk    system clock, rising-edge active
//   reset  asynchronous, active-high reset
//   bus    mult_div_unit_if.slave (start/op/a/b in, hi/lo/busy/done out)
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mult_div_unit_if.slave        bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [CW-1:0]    r_count;
  logic             r_isDiv;
  logic             r_negLo;
  logic             r_negHi;
  logic             r_divZero;
  logic [WIDTH-1:0] r_rawA;
  logic [WIDTH-1:0] r_operB;
  // r_accHi is one bit wider than a word so the multiply add keeps its carry
  logic [WIDTH:0]   r_accHi;
  logic [WIDTH-1:0] r_low;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_accept;
  logic             w_lastIter;
  logic             w_signedOp;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_divShifted;
  logic [WIDTH+1:0] w_divTrial;
  logic             w_qBit;
  logic [2*WIDTH-1:0] w_prodMag;
  logic [2*WIDTH-1:0] w_prodFinal;
  logic [WIDTH-1:0] w_quotFinal;
  logic [WIDTH-1:0] w_remFinal;

  // Operand conditioning: signed ops iterate on magnitudes and fix the sign
  // at the end, so the core loops only ever see unsigned values.
  assign w_signedOp = ~bus.op[0];
  assign w_absA     = (w_signedOp && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_absB     = (w_signedOp && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign w_lastIter = (r_count == CW'(WIDTH - 1));

  // One shift-add step: r_low holds the not-yet-consumed multiplier bits in
  // its low end and the finished product bits shift in at the top.
  assign w_mulSum = r_low[0] ? (r_accHi + {1'b0, r_operB}) : r_accHi;

  // One restoring-divide step: shift the next dividend bit into the partial
  // remainder and try subtracting the divisor; the sign of the trial decides
  // the quotient bit and whether the remainder is restored.
  assign w_divShifted = {r_accHi[WIDTH-1:0], r_low[WIDTH-1]};
  assign w_divTrial   = {1'b0, w_divShifted} - {2'b00, r_operB};
  assign w_qBit       = ~w_divTrial[WIDTH+1];

  // Fix-up values. Negating the magnitude results gives truncation toward
  // zero and a remainder that follows the dividend. The 0x80000000 / -1
  // overflow comes out as 0x80000000 / 0 naturally because negating
  // 0x80000000 wraps back to itself.
  assign w_prodMag   = {r_accHi[WIDTH-1:0], r_low};
  assign w_prodFinal = r_negLo ? -w_prodMag : w_prodMag;
  assign w_quotFinal = r_negLo ? -r_low : r_low;
  assign w_remFinal  = r_negHi ? -r_accHi[WIDTH-1:0] : r_accHi[WIDTH-1:0];

  // State register for the control FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a mul/div request is only taken in IDLE, RUN lasts
  // exactly WIDTH edges, and FIX always returns to IDLE after one edge.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.op[2]) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_lastIter) begin
          w_nextState = FIX;
        end
      end
      FIX: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath and architectural registers. HI/LO only move on an MTHI/MTLO
  // in IDLE or at the FIX edge, so a reset during RUN never exposes a
  // partial result. Requests arriving outside IDLE are dropped here simply
  // because only the IDLE branch looks at start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_negLo   <= 1'b0;
      r_negHi   <= 1'b0;
      r_divZero <= 1'b0;
      r_rawA    <= '0;
      r_operB   <= '0;
      r_accHi   <= '0;
      r_low     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_count   <= '0;
            r_isDiv   <= bus.op[1];
            r_negLo   <= w_signedOp & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_negHi   <= w_signedOp & bus.a[WIDTH-1];
            r_divZero <= bus.op[1] && (bus.b == '0);
            r_rawA    <= bus.a;
            r_operB   <= w_absB;
            r_accHi   <= '0;
            r_low     <= w_absA;
          end else if (bus.start && (bus.op == 3'b100)) begin
            r_hi <= bus.a;
          end else if (bus.start && (bus.op == 3'b101)) begin
            r_lo <= bus.a;
          end
        end
        RUN: begin
          r_count <= r_count + CW'(1);
          if (r_isDiv) begin
            if (w_qBit) begin
              r_accHi <= w_divTrial[WIDTH:0];
            end else begin
              r_accHi <= w_divShifted;
            end
            r_low <= {r_low[WIDTH-2:0], w_qBit};
          end else begin
            r_accHi <= {1'b0, w_mulSum[WIDTH:1]};
            r_low   <= {w_mulSum[0], r_low[WIDTH-1:1]};
          end
        end
        FIX: begin
          r_done <= 1'b1;
          if (!r_isDiv) begin
            r_hi <= w_prodFinal[2*WIDTH-1:WIDTH];
            r_lo <= w_prodFinal[WIDTH-1:0];
          end else if (r_divZero) begin
            r_hi <= r_rawA;
            r_lo <= '1;
          end else begin
            r_hi <= w_remFinal;
            r_lo <= w_quotFinal;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS32 pipeline EX stage.
- Consumes the two operands read from the register file (rs/rt values, after forwarding).
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
- Supplies hi/lo to the MFHI/MFLO datapath; busy is used by hazard control to stall HI/LO accesses.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH; only 32 is required to be supported.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  request strobe; sampled on the rising clk edge
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
b  input  WIDTH  rt operand (divisor / multiplier)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  high while a multiply/divide is in progress
done  output  1  one-cycle pulse after HI/LO are committed by a mul/div

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: hi=0, lo=0, busy=0, done=0, FSM=IDLE, all internal accumulators=0.
- Reset asserted mid-operation aborts immediately; no partial result is ever written to hi/lo.

FSM states:
- IDLE -> RUN: start=1 and op in {000..011}.
- RUN -> FIX: after exactly WIDTH iteration edges.
- FIX -> IDLE: after one edge.

Accepting an operation:
- Accept edge E0 (IDLE, start=1, op mul/div): latch |a|, |b| for signed ops (raw values for unsigned ops), latch the result sign flags, clear the accumulator. busy=1 from E0.
- RUN, edges E1..E32: one iteration per edge.
  - Multiply: shift-add, one multiplier bit per edge, 64-bit product.
  - Divide: restoring, one quotient bit per edge.
- FIX, edge E33: apply sign correction and write hi/lo. busy=0 and done=1 after E33; done=0 after E34.
- Latency: start to valid hi/lo = 33 edges. busy is high for exactly 33 cycles.

MTHI/MTLO:
- Accepted only in IDLE: hi<=a (MTHI) or lo<=a (MTLO) at that edge.
- No busy, no done.

Ignored requests:
- start while busy is ignored entirely, including MTHI/MTLO. Operands need not be held after E0.
- op 11x with start=1 changes nothing.

Results:
- Multiply: {hi,lo} = full 64-bit product; signed for MULT, unsigned for MULTU.
- DIV: quotient truncates toward zero into lo; remainder takes the sign of the dividend, into hi.
- DIVU: unsigned quotient into lo, unsigned remainder into hi.

Divide boundary cases:
- Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=a. Full 33-cycle latency.
- DIV overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.

Output timing:
- hi/lo change only at a FIX edge, at an MTHI/MTLO edge, or on reset.
- During RUN, hi/lo hold their previous values.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high for 33 cycles, then hi=0xFFFFFFFE lo=0x00000001, done high for one cycle.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1. MULT a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3 hi=1. DIVU a=0xFFFFFFF9 b=2 -> lo=0x7FFFFFFC hi=1.
- DIV a=0x12345678 b=0 -> lo=0xFFFFFFFF hi=0x12345678. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- Handshake, in order:
  1. Idle MTLO a=0xCAFEF00D -> lo=0xCAFEF00D after one edge, busy stays 0.
  2. During a DIVU, issue start with MULT and then MTHI -> both ignored; the DIVU result is unaffected and hi is not overwritten.
- Reset pulse at cycle 10 of a MULTU -> busy=0, hi=lo=0 immediately without waiting for a clock edge, and done never pulses. A following DIVU 100/7 completes with lo=14 hi=2.
